// File: rtl/pri_sel_rr_if.sv
// Request/result bundle for pri_sel_rr: per-port priority words in,
// survivor words, grant and winning priority out.
interface pri_sel_rr_if #(
  parameter int N  = 16,
  parameter int C  = 7,
  parameter int IW = 4
);
  logic [C-1:0]  in [0:N-1];
  logic          start;
  logic          busy;
  logic          valid;
  logic [C-1:0]  out [0:N-1];
  logic [N-1:0]  req_out;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic [C-1:0]  max_val;

  modport master (
    output in, start,
    input  busy, valid, out, req_out, gnt, gnt_idx, max_val
  );

  modport slave (
    input  in, start,
    output busy, valid, out, req_out, gnt, gnt_idx, max_val
  );
endinterface

// File: rtl/pri_sel_rr.sv
// Multi-bit-per-step priority selector: narrows N priority words MSB-first to the
// maximum non-zero set, then picks one survivor by round-robin or lowest index.
module pri_sel_rr #(
  parameter int N      = 16,
  parameter int P      = 128,
  parameter int C      = $clog2(P),
  parameter int B      = 1,
  parameter int TIE_RR = 1
) (
  input  logic       clk,
  input  logic       reset,
  pri_sel_rr_if.slave bus
);
  localparam int S  = C / B;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = (S > 1) ? $clog2(S) : 1;

  generate
    if (C % B != 0) begin : g_bad_digit_width
      $error("pri_sel_rr: C must be a multiple of B");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg, state_next;
  logic          load, run_step, finish;

  logic [C-1:0]  data_reg [0:N-1];
  logic [N-1:0]  mask_reg;
  logic [N-1:0]  mask_load;
  logic [N-1:0]  mask_run;
  logic [SW-1:0] step_reg;
  logic [C-1:0]  acc_reg;
  logic [C-1:0]  acc_next;
  logic [IW-1:0] ptr_reg;

  logic [B-1:0]  digit [0:N-1];
  logic [B-1:0]  dmax;
  int            shamt;

  logic [C-1:0]  out_reg [0:N-1];
  logic [N-1:0]  req_reg;
  logic [N-1:0]  gnt_reg;
  logic [N-1:0]  gnt_next;
  logic [IW-1:0] idx_reg;
  logic [IW-1:0] idx_next;
  logic          gnt_found;
  logic [C-1:0]  max_reg;
  logic          valid_reg;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    run_step   = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        run_step = 1'b1;
        if (step_reg == SW'(S - 1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- digit narrowing ----------------
  always_comb begin
    shamt = C - B - int'(step_reg) * B;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_port
      assign digit[gi]     = B'(data_reg[gi] >> shamt);
      assign mask_load[gi] = |bus.in[gi];
      assign mask_run[gi]  = mask_reg[gi] && (digit[gi] == dmax);
    end
  endgenerate

  // An empty mask leaves dmax at 0, so an all-zero request yields max_val 0.
  always_comb begin
    dmax = '0;
    for (int i = 0; i < N; i++) begin
      if (mask_reg[i] && (digit[i] > dmax)) begin
        dmax = digit[i];
      end
    end
  end

  assign acc_next = C'({acc_reg, dmax});

  // ---------------- tie-break over the final survivors ----------------
  always_comb begin
    int k;
    k         = 0;
    gnt_next  = '0;
    idx_next  = '0;
    gnt_found = 1'b0;
    for (int j = 0; j < N; j++) begin
      k = (((TIE_RR != 0) ? int'(ptr_reg) : 0) + j) % N;
      if (!gnt_found && mask_run[k]) begin
        gnt_found   = 1'b1;
        gnt_next[k] = 1'b1;
        idx_next    = IW'(k);
      end
    end
  end

  // ---------------- datapath and result registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        data_reg[i] <= '0;
        out_reg[i]  <= '0;
      end
      mask_reg  <= '0;
      step_reg  <= '0;
      acc_reg   <= '0;
      ptr_reg   <= '0;
      req_reg   <= '0;
      gnt_reg   <= '0;
      idx_reg   <= '0;
      max_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= finish;
      if (load) begin
        for (int i = 0; i < N; i++) begin
          data_reg[i] <= bus.in[i];
        end
        mask_reg <= mask_load;
        step_reg <= '0;
        acc_reg  <= '0;
      end else if (run_step) begin
        mask_reg <= mask_run;
        step_reg <= step_reg + 1'b1;
        acc_reg  <= acc_next;
      end
      if (finish) begin
        for (int i = 0; i < N; i++) begin
          out_reg[i] <= mask_run[i] ? data_reg[i] : '0;
        end
        req_reg <= mask_run;
        gnt_reg <= gnt_next;
        idx_reg <= idx_next;
        max_reg <= acc_next;
        if ((TIE_RR != 0) && gnt_found) begin
          ptr_reg <= (idx_next == IW'(N - 1)) ? '0 : idx_next + 1'b1;
        end
      end
    end
  end

  assign bus.busy    = (state_reg == RUN);
  assign bus.valid   = valid_reg;
  assign bus.req_out = req_reg;
  assign bus.gnt     = gnt_reg;
  assign bus.gnt_idx = idx_reg;
  assign bus.max_val = max_reg;

  generate
    for (gi = 0; gi < N; gi++) begin : g_out
      assign bus.out[gi] = out_reg[gi];
    end
  endgenerate
endmodule

// File: tb/tb_pri_sel_rr.sv
// Scoreboard bench for pri_sel_rr: three instances (round-robin, fixed-priority,
// 2-bit digits); expectations queued at launch, checked by per-instance monitors.
module tb_pri_sel_rr;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pri_sel_rr_if #(.N(16), .C(7), .IW(4)) ifa ();
  pri_sel_rr_if #(.N(16), .C(7), .IW(4)) ifb ();
  pri_sel_rr_if #(.N(16), .C(8), .IW(4)) ifc ();

  pri_sel_rr #(.N(16), .P(128), .B(1), .TIE_RR(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  pri_sel_rr #(.N(16), .P(128), .B(1), .TIE_RR(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
  pri_sel_rr #(.N(16), .P(256), .B(2), .TIE_RR(1)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

  typedef struct packed {
    logic [15:0]  req;
    logic [15:0]  gnt;
    logic [3:0]   idx;
    logic [7:0]   maxv;
    logic [127:0] outs;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic [15:0] mask_exp_c [0:3] = '{16'h0003, 16'h0003, 16'h0003, 16'h0001};

  task automatic check(string name, logic [127:0] act, logic [127:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic cmp(string tag, exp_t e, exp_t a);
    $display("%s result: req=%h gnt=%h idx=%0d max=%0h", tag, a.req, a.gnt, a.idx, a.maxv);
    check({tag, "_req"},  128'(a.req),  128'(e.req));
    check({tag, "_gnt"},  128'(a.gnt),  128'(e.gnt));
    check({tag, "_idx"},  128'(a.idx),  128'(e.idx));
    check({tag, "_max"},  128'(a.maxv), 128'(e.maxv));
    check({tag, "_outs"}, a.outs,       e.outs);
  endtask

  function automatic logic [127:0] ov(int idx, int v);
    return 128'(v) << (idx * 8);
  endfunction

  function automatic exp_t mk(int req, int idx, int maxv, logic [127:0] outs);
    exp_t e;
    e.req  = 16'(req);
    e.gnt  = (req == 0) ? 16'h0 : (16'h1 << idx);
    e.idx  = 4'(idx);
    e.maxv = 8'(maxv);
    e.outs = outs;
    return e;
  endfunction

  function automatic exp_t snap_a();
    exp_t s;
    s.req = ifa.req_out; s.gnt = ifa.gnt; s.idx = ifa.gnt_idx; s.maxv = {1'b0, ifa.max_val};
    s.outs = '0;
    for (int i = 0; i < 16; i++) s.outs[i*8 +: 8] = {1'b0, ifa.out[i]};
    return s;
  endfunction

  function automatic exp_t snap_b();
    exp_t s;
    s.req = ifb.req_out; s.gnt = ifb.gnt; s.idx = ifb.gnt_idx; s.maxv = {1'b0, ifb.max_val};
    s.outs = '0;
    for (int i = 0; i < 16; i++) s.outs[i*8 +: 8] = {1'b0, ifb.out[i]};
    return s;
  endfunction

  function automatic exp_t snap_c();
    exp_t s;
    s.req = ifc.req_out; s.gnt = ifc.gnt; s.idx = ifc.gnt_idx; s.maxv = ifc.max_val;
    s.outs = '0;
    for (int i = 0; i < 16; i++) s.outs[i*8 +: 8] = ifc.out[i];
    return s;
  endfunction

  // Monitors: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ifa.valid) begin
      if (qa.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL a_spurious_valid: got a valid pulse, expected none");
      end else cmp("a", qa.pop_front(), snap_a());
    end
    if (ifb.valid) begin
      if (qb.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL b_spurious_valid: got a valid pulse, expected none");
      end else cmp("b", qb.pop_front(), snap_b());
    end
    if (ifc.valid) begin
      if (qc.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL c_spurious_valid: got a valid pulse, expected none");
      end else cmp("c", qc.pop_front(), snap_c());
    end
  end

  task automatic set_in(int which, int idx, int v);
    case (which)
      0: ifa.in[idx] = 7'(v);
      1: ifb.in[idx] = 7'(v);
      default: ifc.in[idx] = 8'(v);
    endcase
  endtask

  task automatic clear_in(int which);
    for (int i = 0; i < 16; i++) set_in(which, i, 0);
  endtask

  task automatic set_start(int which, logic v);
    case (which)
      0: ifa.start = v;
      1: ifb.start = v;
      default: ifc.start = v;
    endcase
  endtask

  function automatic logic get_valid(int which);
    case (which)
      0: return ifa.valid;
      1: return ifb.valid;
      default: return ifc.valid;
    endcase
  endfunction

  function automatic logic get_busy(int which);
    case (which)
      0: return ifa.busy;
      1: return ifb.busy;
      default: return ifc.busy;
    endcase
  endfunction

  task automatic set_tie(int which);
    clear_in(which);
    set_in(which, 2, 90); set_in(which, 5, 90); set_in(which, 12, 90); set_in(which, 7, 89);
  endtask

  // One start pulse; checks latency from E0 to valid and busy duration.
  task automatic run(int which, int exp_lat);
    int   lat;
    int   bc;
    logic found;
    lat = 0; bc = 0; found = 1'b0;
    @(posedge clk); #1 set_start(which, 1'b1);
    @(posedge clk); #1 set_start(which, 1'b0);
    for (int k = 1; k <= 40 && !found; k++) begin
      if (get_busy(which)) bc++;
      @(posedge clk); #1;
      if (which == 2 && k <= 4) check("c_mask_step", 128'(dut_c.mask_reg), 128'(mask_exp_c[k-1]));
      if (get_valid(which)) begin
        found = 1'b1;
        lat   = k;
      end
    end
    if (!found) begin
      n_vec++; n_bad++;
      $display("FAIL run_timeout: got no valid in 40 cycles, expected one after %0d", exp_lat);
    end else begin
      check("latency", 128'(lat), 128'(exp_lat));
      check("busy_cycles", 128'(bc), 128'(exp_lat));
    end
  endtask

  logic [127:0] tie_outs;
  int           gap;
  logic         seen;

  initial begin
    ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
    clear_in(0); clear_in(1); clear_in(2);
    tie_outs = ov(2, 90) | ov(5, 90) | ov(12, 90);

    #2 reset = 1'b0;
    #1;
    cmp("a_por", '0, snap_a());
    check("a_por_busy",  128'(ifa.busy),  128'(0));
    check("a_por_valid", 128'(ifa.valid), 128'(0));
    check("c_por_busy",  128'(ifc.busy),  128'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // round-robin tie among ports 2, 5, 12
    set_tie(0);
    qa.push_back(mk(16'h1024, 2, 90, tie_outs));  run(0, 7);
    qa.push_back(mk(16'h1024, 5, 90, tie_outs));  run(0, 7);
    qa.push_back(mk(16'h1024, 12, 90, tie_outs)); run(0, 7);
    qa.push_back(mk(16'h1024, 2, 90, tie_outs));  run(0, 7);

    // fixed lowest-index tie-break
    set_tie(1);
    for (int r = 0; r < 4; r++) begin
      qb.push_back(mk(16'h1024, 2, 90, tie_outs));
      run(1, 7);
    end

    // no requests: empty result, pointer (3) untouched
    clear_in(0);
    qa.push_back(mk(0, 0, 0, '0)); run(0, 7);
    set_tie(0);
    qa.push_back(mk(16'h1024, 5, 90, tie_outs)); run(0, 7);

    // basic maximum
    clear_in(0); set_in(0, 3, 100); set_in(0, 9, 37);
    qa.push_back(mk(16'h0008, 3, 100, ov(3, 100))); run(0, 7);

    // 2-bit digits, 8-bit words
    set_in(2, 0, 8'hC3); set_in(2, 1, 8'hC1); set_in(2, 4, 8'h7F);
    qc.push_back(mk(16'h0001, 0, 8'hC3, ov(0, 8'hC3))); run(2, 4);

    // reset in the middle of a run
    set_tie(0);
    @(posedge clk); #1 ifa.start = 1'b1;
    @(posedge clk); #1 ifa.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    cmp("a_midreset", '0, snap_a());
    check("a_midreset_busy",  128'(ifa.busy),  128'(0));
    check("a_midreset_valid", 128'(ifa.valid), 128'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    qa.push_back(mk(16'h1024, 2, 90, tie_outs)); run(0, 7);
    clear_in(0); set_in(0, 6, 5);
    qa.push_back(mk(16'h0040, 6, 5, ov(6, 5))); run(0, 7);

    // start held high: back-to-back runs every S+1 cycles
    clear_in(0); set_in(0, 1, 10);
    for (int r = 0; r < 3; r++) qa.push_back(mk(16'h0002, 1, 10, ov(1, 10)));
    @(posedge clk); #1 ifa.start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      gap = 0; seen = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
        @(posedge clk); #1;
        if (ifa.valid) begin
          seen = 1'b1;
          gap  = k;
        end
      end
      if (r == 2) ifa.start = 1'b0;
      check("held_start_gap", 128'(gap), 128'(8));
    end

    repeat (12) @(posedge clk);
    #1;
    check("qa_drained", 128'(qa.size()), 128'(0));
    check("qb_drained", 128'(qb.size()), 128'(0));
    check("qc_drained", 128'(qc.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pri_sel_rr.md
Name: pri_sel_rr

Overview:
- Parametrised successor to the 7-bit bit-serial priority selector in the pSLIP arbiter path.
- Takes N per-port priority words and narrows them, MSB-first, to the set holding the maximum non-zero priority.
- Resolves B bits per cycle instead of a fixed 1, so latency is configurable.
- Adds a round-robin one-hot tie-break grant, the winning priority value and a busy/valid handshake.

Parameters:
- N, 16, number of request ports.
- P, 128, number of priority levels.
- C, $clog2(P), priority word width.
- B, 1, bits resolved per step. C % B must equal 0; elaboration error otherwise.
- TIE_RR, 1, 1 = round-robin tie-break; 0 = fixed lowest-index tie-break.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in  in  [C-1:0] x [0:N-1]  per-port priority words; 0 means no request.
- start  in  1  launch a selection; sampled only when not busy.
- busy  out  1  high while a selection is in progress.
- valid  out  1  one-cycle pulse when the result registers update.
- out  out  [C-1:0] x [0:N-1]  survivor words; non-survivors forced to 0.
- req_out  out  N  survivor mask; req_out[i] = |out[i].
- gnt  out  N  one-hot winner among survivors; 0 if no survivors.
- gnt_idx  out  $clog2(N)  index of the winner; 0 if no winner.
- max_val  out  C  winning priority; 0 if none.

Behaviour:
- Definitions: S = C/B steps; digit k = bits [C-1-k*B -: B].
- States: IDLE, RUN. busy = (state == RUN).
- Launch, edge E0: IDLE and start=1 → capture in into data regs; survivor mask m[i] = |in[i]; step = 0; go to RUN. start in IDLE with start=0 keeps IDLE.
- Each RUN edge:
  - dmax = max of digit step over ports with m[i]=1.
  - Clear m[i] for every survivor whose digit ≠ dmax.
  - Append dmax to the max_val accumulator.
  - step++.
- Survivor set never empties unless it started empty.
  - Empty mask → dmax = 0; the mask stays empty.
- Final step, edge ES = E0+S:
  - out[i] = data[i] if m[i] else 0.
  - Load req_out, max_val, gnt and gnt_idx.
  - valid = 1 for exactly the next cycle; return to IDLE.
- start during RUN is ignored, with no queueing.
- start=1 in the valid cycle launches the next run, so throughput is one result per S+1 cycles.
- Tie-break:
  - TIE_RR=1: gnt selects the first survivor at index ≥ ptr, wrapping modulo N.
  - On a valid with gnt ≠ 0: ptr ← gnt_idx+1 mod N.
  - TIE_RR=0: lowest-index survivor wins; ptr unused.
  - No survivors → ptr unchanged.
- Result outputs hold their last values until the next valid.
- Reset value of all outputs is 0. reset=0 at any time, including mid-RUN, immediately clears:
  - state → IDLE, busy=0, valid=0;
  - out, req_out, gnt, gnt_idx, max_val = 0;
  - ptr = 0, and the data, mask and step registers.
  - The aborted run produces no valid.
- in may change freely during RUN; only the E0 capture is used.

Test Plan:
1. Defaults (C=7, B=1): in[3]=100, in[9]=37, others 0, pulse start → valid 7 edges after E0; out[3]=100, all others 0; req_out=0x0008, gnt=0x0008, gnt_idx=3, max_val=100; busy high for exactly 7 cycles.
2. Round-robin tie: in[2]=in[5]=in[12]=90, in[7]=89, others 0, four consecutive runs → req_out=0x1024 each run; gnt_idx sequence 2, 5, 12, 2. Same stimulus with TIE_RR=0 → gnt_idx 2 every run.
3. All in=0, start → valid after 7 edges; req_out=0, gnt=0, gnt_idx=0, max_val=0; ptr unchanged (next tie run still starts its search at the previous ptr).
4. P=256, B=2 (S=4): in[0]=0xC3, in[1]=0xC1, in[4]=0x7F → valid 4 edges after E0; survivors {0}, max_val=0xC3, gnt_idx=0. Check the mask after each step: {0,1} → {0,1} → {0,1} → {0}.
5. Reset asserted after the 3rd RUN edge → all outputs 0 asynchronously, before the next clock edge; no valid appears. After release, a start with in[6]=5 gives gnt_idx=6 and ptr starts at 0.
6. start held high continuously with in[1]=10 → starts during RUN are ignored; valid pulses every 8 cycles; each valid cycle's start is accepted back-to-back.
